// File: rtl/vram_blit_writer.sv
// VRAM write-side blit engine: fill and forward-copy commands, executed only in
// VRAM slots granted by the video generator through blit_cycle_i.
module vram_blit_writer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              blit_cycle_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_copy_i,
    input  logic [ADDR_W-1:0] cmd_dst_i,
    input  logic [ADDR_W-1:0] cmd_src_i,
    input  logic [CNT_W-1:0]  cmd_count_i,
    input  logic [DATA_W-1:0] cmd_fill_i,
    output logic              vram_sel_o,
    output logic              vram_wr_o,
    output logic [ADDR_W-1:0] vram_addr_o,
    output logic [DATA_W-1:0] vram_data_o,
    input  logic [DATA_W-1:0] vram_data_i,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {IDLE, FILL, COPY_RD, COPY_WAIT, COPY_WR} state_t;

    state_t            state, state_n;
    logic              req, req_n;
    logic              wr_n;
    logic [ADDR_W-1:0] addr_n, dst, dst_n, src, src_n;
    logic [DATA_W-1:0] data_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              done_n;
    logic              grant;

    assign grant       = req & blit_cycle_i;
    assign vram_sel_o  = grant;
    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state       <= IDLE;
            req         <= 1'b0;
            vram_wr_o   <= 1'b0;
            vram_addr_o <= '0;
            vram_data_o <= '0;
            dst         <= '0;
            src         <= '0;
            cnt         <= '0;
            done_o      <= 1'b0;
        end else begin
            state       <= state_n;
            req         <= req_n;
            vram_wr_o   <= wr_n;
            vram_addr_o <= addr_n;
            vram_data_o <= data_n;
            dst         <= dst_n;
            src         <= src_n;
            cnt         <= cnt_n;
            done_o      <= done_n;
        end
    end

    // vram_data_o doubles as the copy buffer: the word read in COPY_WAIT is
    // exactly the word presented for the following COPY_WR.
    always_comb begin
        state_n = state;
        req_n   = req;
        wr_n    = vram_wr_o;
        addr_n  = vram_addr_o;
        data_n  = vram_data_o;
        dst_n   = dst;
        src_n   = src;
        cnt_n   = cnt;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    dst_n = cmd_dst_i;
                    src_n = cmd_src_i;
                    cnt_n = cmd_count_i;
                    if (cmd_count_i == '0) begin
                        done_n = 1'b1;
                    end else if (cmd_copy_i) begin
                        state_n = COPY_RD;
                        req_n   = 1'b1;
                        wr_n    = 1'b0;
                        addr_n  = cmd_src_i;
                    end else begin
                        state_n = FILL;
                        req_n   = 1'b1;
                        wr_n    = 1'b1;
                        addr_n  = cmd_dst_i;
                        data_n  = cmd_fill_i;
                    end
                end
            end
            FILL: begin
                if (grant) begin
                    dst_n  = dst + ADDR_W'(1);
                    cnt_n  = cnt - CNT_W'(1);
                    addr_n = dst + ADDR_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                        wr_n    = 1'b0;
                        done_n  = 1'b1;
                    end
                end
            end
            COPY_RD: begin
                if (grant) begin
                    src_n   = src + ADDR_W'(1);
                    state_n = COPY_WAIT;
                    req_n   = 1'b0;
                end
            end
            COPY_WAIT: begin
                state_n = COPY_WR;
                req_n   = 1'b1;
                wr_n    = 1'b1;
                addr_n  = dst;
                data_n  = vram_data_i;
            end
            COPY_WR: begin
                if (grant) begin
                    dst_n = dst + ADDR_W'(1);
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                        wr_n    = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = COPY_RD;
                        wr_n    = 1'b0;
                        addr_n  = src;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_vram_blit_writer.sv
// Directed bench for vram_blit_writer: fill/copy sequences, grant gating,
// wraparound, zero-count, back-to-back acceptance and mid-command reset.
module tb_vram_blit_writer;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        blit_cycle_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_copy_i;
    logic [15:0] cmd_dst_i;
    logic [15:0] cmd_src_i;
    logic [15:0] cmd_count_i;
    logic [15:0] cmd_fill_i;
    logic        vram_sel_o;
    logic        vram_wr_o;
    logic [15:0] vram_addr_o;
    logic [15:0] vram_data_o;
    logic [15:0] vram_data_i;
    logic        busy_o;
    logic        done_o;

    always #5 clk = ~clk;

    vram_blit_writer #(.ADDR_W(16), .DATA_W(16), .CNT_W(16)) dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .blit_cycle_i(blit_cycle_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_copy_i  (cmd_copy_i),
        .cmd_dst_i   (cmd_dst_i),
        .cmd_src_i   (cmd_src_i),
        .cmd_count_i (cmd_count_i),
        .cmd_fill_i  (cmd_fill_i),
        .vram_sel_o  (vram_sel_o),
        .vram_wr_o   (vram_wr_o),
        .vram_addr_o (vram_addr_o),
        .vram_data_o (vram_data_o),
        .vram_data_i (vram_data_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // VRAM read model: data returned the cycle after a read grant is addr ^ 5A00.
    logic        rd_pend;
    logic [15:0] last_rd;

    task automatic tick();
        rd_pend = vram_sel_o && !vram_wr_o;
        last_rd = vram_addr_o;
        @(posedge clk);
        #1;
        vram_data_i = rd_pend ? (last_rd ^ 16'h5A00) : 16'hDEAD;
    endtask

    task automatic issue(input logic copy, input logic [15:0] dst, input logic [15:0] src,
                         input logic [15:0] cnt, input logic [15:0] fill);
        cmd_valid_i = 1'b1;
        cmd_copy_i  = copy;
        cmd_dst_i   = dst;
        cmd_src_i   = src;
        cmd_count_i = cnt;
        cmd_fill_i  = fill;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    logic        g_wr[64];
    logic [15:0] g_addr[64];
    logic [15:0] g_data[64];
    int          g_cyc[64];
    int          ngr, ncyc, viol, unstable, rdy_early;
    logic        busy_seen;

    // mode 0: blit always 1; mode 1: 1100 repeating; mode 2: blit 0 for cycles 4..103
    task automatic run(input int max_cyc, input int mode);
        logic [32:0] held;
        held      = '0;
        ngr       = 0;
        ncyc      = -1;
        viol      = 0;
        unstable  = 0;
        rdy_early = 0;
        busy_seen = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            case (mode)
                1:       blit_cycle_i = ((c - 1) % 4) < 2;
                2:       blit_cycle_i = !(c >= 4 && c <= 103);
                default: blit_cycle_i = 1'b1;
            endcase
            #1;
            if (busy_o) busy_seen = 1'b1;
            if (cmd_ready_o && !done_o) rdy_early++;
            if (vram_sel_o) begin
                if (!blit_cycle_i) viol++;
                if (ngr < 64) begin
                    g_wr[ngr]   = vram_wr_o;
                    g_addr[ngr] = vram_addr_o;
                    g_data[ngr] = vram_data_o;
                    g_cyc[ngr]  = c;
                end
                ngr++;
            end
            if (mode == 2 && c == 4) held = {vram_wr_o, vram_addr_o, vram_data_o};
            if (mode == 2 && c > 4 && c <= 103 &&
                ({vram_wr_o, vram_addr_o, vram_data_o} !== held || vram_sel_o)) unstable++;
            if (done_o) begin
                ncyc = c;
                break;
            end
            tick();
        end
    endtask

    logic        e_wr[6];
    logic [15:0] e_addr[6];
    logic [15:0] e_data[6];
    int          e_cyc[6];
    logic [15:0] ea;

    initial begin
        reset_i      = 1'b1;
        blit_cycle_i = 1'b1;
        cmd_valid_i  = 1'b0;
        cmd_copy_i   = 1'b0;
        cmd_dst_i    = '0;
        cmd_src_i    = '0;
        cmd_count_i  = '0;
        cmd_fill_i   = '0;
        vram_data_i  = 16'hDEAD;
        rd_pend      = 1'b0;
        last_rd      = '0;
        tick();
        tick();
        #1;
        check("rst_ready", cmd_ready_o, 1);
        check("rst_busy",  busy_o, 0);
        check("rst_done",  done_o, 0);
        check("rst_sel",   vram_sel_o, 0);
        check("rst_wr",    vram_wr_o, 0);
        check("rst_addr",  vram_addr_o, 0);
        check("rst_data",  vram_data_o, 0);
        reset_i = 1'b0;
        tick();

        // 1: fill across the address wrap
        issue(1'b0, 16'hFFFE, 16'h0000, 16'd4, 16'h1F41);
        run(20, 0);
        check("t1_done_cyc", ncyc, 5);
        check("t1_grants", ngr, 4);
        check("t1_busy_seen", busy_seen, 1);
        for (int i = 0; i < 4; i++) begin
            ea = 16'hFFFE + 16'(i);
            check($sformatf("t1_addr%0d", i), g_addr[i], ea);
            check($sformatf("t1_data%0d", i), g_data[i], 16'h1F41);
            check($sformatf("t1_wr%0d", i), g_wr[i], 1);
            check($sformatf("t1_cyc%0d", i), g_cyc[i], i + 1);
        end
        check("t1_end_busy", busy_o, 0);
        check("t1_end_ready", cmd_ready_o, 1);

        // 2: copy under a 1100 grant pattern
        issue(1'b1, 16'h0200, 16'h0100, 16'd3, 16'h0000);
        run(60, 1);
        e_wr   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        e_addr = '{16'h0100, 16'h0200, 16'h0101, 16'h0201, 16'h0102, 16'h0202};
        e_data = '{16'h0000, 16'h5B00, 16'h0000, 16'h5B01, 16'h0000, 16'h5B02};
        e_cyc  = '{1, 5, 6, 9, 10, 13};
        check("t2_done_cyc", ncyc, 14);
        check("t2_grants", ngr, 6);
        check("t2_sel_without_blit", viol, 0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2_wr%0d", i), g_wr[i], e_wr[i]);
            check($sformatf("t2_addr%0d", i), g_addr[i], e_addr[i]);
            check($sformatf("t2_cyc%0d", i), g_cyc[i], e_cyc[i]);
            if (e_wr[i]) check($sformatf("t2_data%0d", i), g_data[i], e_data[i]);
        end

        // 3: zero-count command is a no-op with an immediate done
        issue(1'b0, 16'h0900, 16'h0000, 16'd0, 16'hFFFF);
        run(5, 0);
        check("t3_done_cyc", ncyc, 1);
        check("t3_grants", ngr, 0);
        check("t3_busy_seen", busy_seen, 0);

        // 4: valid held through a fill of 8; second command taken on done cycle
        cmd_valid_i = 1'b1;
        cmd_copy_i  = 1'b0;
        cmd_dst_i   = 16'h0300;
        cmd_count_i = 16'd8;
        cmd_fill_i  = 16'h1111;
        tick();
        cmd_dst_i   = 16'h0400;
        cmd_count_i = 16'd2;
        cmd_fill_i  = 16'h2222;
        run(30, 0);
        check("t4_done_cyc", ncyc, 9);
        check("t4_grants", ngr, 8);
        check("t4_ready_while_busy", rdy_early, 0);
        check("t4_ready_at_done", cmd_ready_o, 1);
        for (int i = 0; i < 8; i++) begin
            ea = 16'h0300 + 16'(i);
            check($sformatf("t4_addr%0d", i), g_addr[i], ea);
            check($sformatf("t4_data%0d", i), g_data[i], 16'h1111);
        end
        tick();
        cmd_valid_i = 1'b0;
        run(10, 0);
        check("t4b_first_cyc", g_cyc[0], 1);
        check("t4b_addr0", g_addr[0], 16'h0400);
        check("t4b_data0", g_data[0], 16'h2222);
        check("t4b_addr1", g_addr[1], 16'h0401);
        check("t4b_done_cyc", ncyc, 3);

        // 5: reset on the third grant of a fill of 10
        issue(1'b0, 16'h0500, 16'h0000, 16'd10, 16'h5555);
        blit_cycle_i = 1'b1;
        #1;
        tick();
        tick();
        check("t5_sel3", vram_sel_o, 1);
        check("t5_addr3", vram_addr_o, 16'h0502);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        check("t5_sel", vram_sel_o, 0);
        check("t5_ready", cmd_ready_o, 1);
        check("t5_done", done_o, 0);
        check("t5_busy", busy_o, 0);
        check("t5_addr", vram_addr_o, 0);
        tick();
        run(20, 0);
        check("t5_later_grants", ngr, 0);
        check("t5_later_done", ncyc, -1);

        // 6: 100-cycle grant blackout during a copy
        tick();
        issue(1'b1, 16'h0800, 16'h0700, 16'd2, 16'h0000);
        run(200, 2);
        check("t6_done_cyc", ncyc, 107);
        check("t6_grants", ngr, 4);
        check("t6_unstable", unstable, 0);
        check("t6_sel_without_blit", viol, 0);
        e_wr   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        e_addr = '{16'h0700, 16'h0800, 16'h0701, 16'h0801, 16'h0000, 16'h0000};
        e_data = '{16'h0000, 16'h5D00, 16'h0000, 16'h5D01, 16'h0000, 16'h0000};
        e_cyc  = '{1, 3, 104, 106, 0, 0};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6_wr%0d", i), g_wr[i], e_wr[i]);
            check($sformatf("t6_addr%0d", i), g_addr[i], e_addr[i]);
            check($sformatf("t6_cyc%0d", i), g_cyc[i], e_cyc[i]);
            if (e_wr[i]) check($sformatf("t6_data%0d", i), g_data[i], e_data[i]);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
